jtdsp16_rom_arb: RTL
====================

// Module: jtdsp16_rom_arb
// PURPOSE
//  Shares the single program-ROM port between instruction fetch (PC from the ROM AAU) and table reads
//  (PT-based data reads). Sequences each access with an external ready handshake, bounded by a timeout.
//  Generates the stall that freezes the core clock enable while an access is outstanding.
//  Sits between the ROM AAU/decoder and the ROM or SDRAM controller.
// PARAMETERS
//  AW       16  ROM address width
//  DW       16  ROM data width
//  TIMEOUT  15  cen-cycles to wait for rom_ok before a forced completion (2..255)
// PORTS
//  clk         in   1   clock
//  rst         in   1   asynchronous, active-high reset
//  cen         in   1   clock enable; all state advances only when cen=1
//  fetch_req   in   1   instruction fetch request; held high until instr_vld
//  fetch_addr  in   AW  fetch address (AAU PC)
//  tbl_req     in   1   table read request; held high until tbl_vld
//  tbl_addr    in   AW  table address (AAU PT)
//  instr       out  DW  last fetched instruction word
//  instr_vld   out  1   one-cen pulse: instr updated
//  tbl_data    out  DW  last table word
//  tbl_vld     out  1   one-cen pulse: tbl_data updated
//  stall       out  1   core must hold its cen low (combinational)
//  err         out  1   sticky: a timeout occurred
//  rom_cs      out  1   ROM access strobe
//  rom_addr    out  AW  ROM address, stable while rom_cs=1
//  rom_data    in   DW  ROM read data, valid when rom_ok=1
//  rom_ok      in   1   ROM ready; completes the access in that cycle
// BEHAVIOUR
//  - Reset (async): state=IDLE; rom_cs=0; rom_addr, instr, tbl_data=0; vld pulses=0; err=0; pend_fetch=0; cnt=0.
//  - FSM states: IDLE, FETCH, TABLE. Transitions occur on cen only; with cen=0 all registers hold,
//    including cnt. Vld pulses stay high until the next cen cycle.
//  - In IDLE (cen=1):
//    - tbl_req=1 -> TABLE, rom_addr<=tbl_addr. If fetch_req=1 too, pend_fetch<=1 (table wins).
//    - else fetch_req=1 -> FETCH, rom_addr<=fetch_addr.
//    - Either move sets rom_cs<=1 and cnt<=0.
//  - In FETCH/TABLE, access done = rom_ok | (cnt==TIMEOUT-1).
//    - done=0: cnt<=cnt+1.
//    - done=1 in FETCH: instr<=rom_ok?rom_data:0; instr_vld<=1.
//    - done=1 in TABLE: tbl_data<=rom_ok?rom_data:0; tbl_vld<=1.
//    - timeout completion (rom_ok=0) also sets err<=1, which clears only on rst.
//  - After done in TABLE with pend_fetch=1: go straight to FETCH with rom_addr<=fetch_addr, rom_cs stays 1,
//    pend_fetch<=0, cnt<=0. There is no idle gap. Otherwise: IDLE, rom_cs<=0.
//  - Minimum latency: request seen in IDLE at cycle N; rom_cs=1 from N+1; with rom_ok=1 at N+1, vld at N+2.
//  - stall = (state!=IDLE & ~(done & ~pend_fetch)) | (state==IDLE & (fetch_req|tbl_req)).
//    stall drops combinationally in the completing cycle, so the core advances together with the vld update.
//  - Requests seen outside IDLE are ignored; requesters hold req/addr stable (core is stalled).
//  - rom_addr changes only on IDLE->access or TABLE->FETCH chaining. Never while waiting.
//  - rom_ok while in IDLE is ignored. rst mid-access drops rom_cs at once; the access is abandoned with no vld.
// TESTING
//  - fetch_req, fetch_addr=0x0123, rom_ok=1 next cycle, rom_data=0xA5A5:
//    rom_addr=0x0123, rom_cs 1 cycle, instr=0xA5A5, instr_vld 1 pulse, err=0.
//  - tbl_req+fetch_req same cycle, tbl_addr=0x0800, fetch_addr=0x0010:
//    TABLE then FETCH back-to-back, rom_cs continuous, tbl_vld before instr_vld, stall high throughout.
//  - fetch with rom_ok held low 3 cycles, then high:
//    rom_addr stable 4 cycles, stall high, instr captured on 4th cycle, cnt resets.
//  - rom_ok never asserted, TIMEOUT=15: completion after 15 cycles, instr=0, instr_vld pulse, err=1 sticky.
//  - cen toggling 1/0 during a wait: state and cnt frozen on cen=0; timeout counts only cen cycles.
//  - rst asserted mid-TABLE: rom_cs=0 immediately, no tbl_vld, next request restarts from IDLE cleanly.

Source files
------------

// File: rtl/jtdsp16_rom_arb.sv
// rtl/jtdsp16_rom_arb.sv - program-ROM port arbiter between instruction fetch and table reads
module jtdsp16_rom_arb #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    input  logic          tbl_req,
    input  logic [AW-1:0] tbl_addr,
    output logic [DW-1:0] instr,
    output logic          instr_vld,
    output logic [DW-1:0] tbl_data,
    output logic          tbl_vld,
    output logic          stall,
    output logic          err,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    input  logic          rom_ok
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_TABLE = 2'd2
    } state_t;

    // Last wait-count value before the access is forced to complete
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [7:0]    r_cnt;
    logic          r_pend_fetch;
    logic          r_rom_cs;
    logic [AW-1:0] r_rom_addr;
    logic [DW-1:0] r_instr;
    logic          r_instr_vld;
    logic [DW-1:0] r_tbl_data;
    logic          r_tbl_vld;
    logic          r_err;
    logic          w_busy;
    logic          w_done;
    logic [DW-1:0] w_rd_word;

    assign w_busy    = (r_state != S_IDLE);
    assign w_done    = w_busy & (rom_ok | (r_cnt == LP_CNT_LAST));
    // A timed-out access returns zero rather than whatever is on the bus
    assign w_rd_word = rom_ok ? rom_data : '0;

    // The core may run again in the cycle the last queued access completes
    assign stall = (w_busy & ~(w_done & ~r_pend_fetch)) |
                   (~w_busy & (fetch_req | tbl_req));

    assign instr     = r_instr;
    assign instr_vld = r_instr_vld;
    assign tbl_data  = r_tbl_data;
    assign tbl_vld   = r_tbl_vld;
    assign err       = r_err;
    assign rom_cs    = r_rom_cs;
    assign rom_addr  = r_rom_addr;

    // State register, advancing only on enabled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else if (cen)
            r_state <= w_next_state;
    end

    // Next-state selection: table reads win, a pending fetch chains after the table read
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (tbl_req)
                    w_next_state = S_TABLE;
                else if (fetch_req)
                    w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (w_done)
                    w_next_state = S_IDLE;
            end
            S_TABLE: begin
                if (w_done)
                    w_next_state = r_pend_fetch ? S_FETCH : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Access sequencing: address/strobe, wait counter, data capture and valid pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_pend_fetch <= 1'b0;
            r_rom_cs     <= 1'b0;
            r_rom_addr   <= '0;
            r_instr      <= '0;
            r_instr_vld  <= 1'b0;
            r_tbl_data   <= '0;
            r_tbl_vld    <= 1'b0;
            r_err        <= 1'b0;
        end else if (cen) begin
            r_instr_vld <= 1'b0;
            r_tbl_vld   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tbl_req) begin
                        r_rom_addr   <= tbl_addr;
                        r_pend_fetch <= fetch_req;
                        r_rom_cs     <= 1'b1;
                        r_cnt        <= '0;
                    end else if (fetch_req) begin
                        r_rom_addr <= fetch_addr;
                        r_rom_cs   <= 1'b1;
                        r_cnt      <= '0;
                    end
                end
                S_FETCH: begin
                    if (w_done) begin
                        r_instr     <= w_rd_word;
                        r_instr_vld <= 1'b1;
                        r_rom_cs    <= 1'b0;
                        if (!rom_ok)
                            r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_TABLE: begin
                    if (w_done) begin
                        r_tbl_data <= w_rd_word;
                        r_tbl_vld  <= 1'b1;
                        if (!rom_ok)
                            r_err <= 1'b1;
                        if (r_pend_fetch) begin
                            r_rom_addr   <= fetch_addr;
                            r_pend_fetch <= 1'b0;
                            r_cnt        <= '0;
                        end else begin
                            r_rom_cs <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_rom_cs <= 1'b0;
            endcase
        end
    end

endmodule
